ddr_request_queue: RTL and testbench
====================================

// Module: ddr_request_queue
// PURPOSE
// - Request buffer directly upstream of ddr_controller: accepts read/write requests from the core over valid/ready.
// - Queues up to DEPTH requests and drives ddr_controller one request at a time.
// - Holds the enables until mem_ready, then returns the response to the requester over valid/ready.
// PARAMETERS
// - DEPTH           4   request FIFO entries; power of 2, >=2
// - ADDR_W          32  request/memory address width
// - DATA_W          32  data width
// - TIMEOUT_CYCLES  64  ISSUE cycles without mem_ready before abort (DDRQ_TIMEOUT_EN only)
// PORTS
// - clk              in   1        clock, rising edge
// - reset            in   1        asynchronous, active-high
// - req_valid        in   1        request present
// - req_ready        out  1        queue can accept; = !full
// - req_write        in   1        1=write, 0=read
// - req_addr         in   ADDR_W   byte address, passed unmodified
// - req_wdata        in   DATA_W   write data (ignored for reads)
// - rsp_valid        out  1        response present; held until rsp_ready
// - rsp_ready        in   1        requester takes response
// - rsp_write        out  1        response is a write ack
// - rsp_rdata        out  DATA_W   read data; 0 for write acks
// - rsp_err          out  1        response aborted by timeout
// - mem_address      out  ADDR_W   to ddr_controller.address
// - mem_write_data   out  DATA_W   to ddr_controller.write_data
// - mem_read_enable  out  1        to ddr_controller.read_enable
// - mem_write_enable out  1        to ddr_controller.write_enable
// - mem_read_data    in   DATA_W   from ddr_controller.read_data
// - mem_ready        in   1        from ddr_controller.ready
// - queue_count      out  $clog2(DEPTH)+1  FIFO occupancy
// - busy             out  1        FSM != IDLE or queue_count != 0
// - timeout_err      out  1        sticky timeout flag; cleared only by reset
// BEHAVIOUR
// - Reset (async): FIFO empty; FSM=IDLE; all outputs 0, except req_ready=1.
// - FIFO: push on req_valid & req_ready; entry = {write, addr, wdata}; in-order; pointers wrap mod DEPTH.
// - Full: req_ready=0 even if a pop occurs in the same cycle; refused requests are not stored.
// - Simultaneous push and pop (not full): count unchanged, both take effect.
// - FSM states: IDLE, ISSUE, RESP. All mem_* outputs are registered.
//   - IDLE: if count>0, pop head and load mem_address/mem_write_data at the edge. Set mem_write_enable=write and mem_read_enable=!write, then go ISSUE.
//   - ISSUE: enables and address held stable.
//     - On mem_ready=1: drop both enables and load rsp_rdata=(read ? mem_read_data : 0).
//     - Also set rsp_write=write, rsp_err=0, rsp_valid=1, then go RESP.
//   - RESP: enables 0 (guarantees >=1 idle cycle between memory operations). On rsp_valid & rsp_ready: rsp_valid=0, then go IDLE.
// - Exactly one operation is outstanding to the controller. Read and write enables are never both high.
// - A write is not acknowledged before mem_ready.
// - Latency: request accepted at edge E0 into an empty, idle queue:
//   - E1: pop, enable high.
//   - Controller ready visible after E2.
//   - E3: rsp_valid=1.
//   - Minimum request-to-response is 3 cycles.
//   - Back-to-back throughput is 1 op per 4 cycles with rsp_ready held at 1.
// - mem_ready seen in IDLE or RESP is ignored.
// - The FIFO keeps accepting requests during ISSUE and RESP.
// - Reset mid-operation: the in-flight op and all queued entries are dropped, and enables drop immediately.
// CONFIGURATION
// - DDRQ_TIMEOUT_EN defined:
//   - A cycle counter clears on ISSUE entry and increments each cycle in ISSUE.
//   - If the count reaches TIMEOUT_CYCLES with mem_ready still 0: drop enables, set rsp_valid=1, rsp_err=1, rsp_rdata=0, timeout_err=1, then go RESP.
//   - The queue continues with the next entry afterwards.
// - DDRQ_TIMEOUT_EN undefined: no counter; ISSUE waits indefinitely; rsp_err and timeout_err are tied 0.
// TESTING
// - Write addr=0x10 data=0xDEADBEEF, then read 0x10 -> write ack (rsp_write=1), then read rsp_rdata=0xDEADBEEF.
//   - Enables are never both high; each enable is held until mem_ready.
// - Push 5 writes back-to-back with rsp_ready=0, DEPTH=4:
//   - 1st is popped to the controller; queue fills to 4; req_ready=0; the 6th request is refused.
//   - Release rsp_ready -> 5 acks in order.
// - Single read accepted at E0 on an idle queue -> mem_read_enable high after E1, rsp_valid high after E3.
//   - With rsp_ready held 0, rsp_valid and rsp_rdata stay stable.
// - Assert reset during ISSUE with 3 queued -> enables, rsp_valid and queue_count are 0 immediately; no response emitted after release.
// - DDRQ_TIMEOUT_EN on, TIMEOUT_CYCLES=8, mem_ready stuck 0:
//   - rsp_err=1 and timeout_err=1 after 8 ISSUE cycles.
//   - Next queued op issues; timeout_err stays 1 until reset.

Source files
------------

// File: rtl/ddr_request_queue.sv
// Request FIFO plus a single-outstanding issue FSM that sits in front of ddr_controller.
// Build option: define DDRQ_TIMEOUT_EN to abort ISSUE after TIMEOUT_CYCLES without mem_ready.
module ddr_request_queue #(
    parameter int DEPTH          = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_write,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [DATA_W-1:0]      mem_write_data,
    output logic                   mem_read_enable,
    output logic                   mem_write_enable,
    input  logic [DATA_W-1:0]      mem_read_data,
    input  logic                   mem_ready,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   busy,
    output logic                   timeout_err
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               push;
    logic               pop;
    logic               issue_done;
    logic               issue_timeout;
    logic               rsp_take;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign req_ready   = !full;
    assign queue_count = count_q;
    assign busy        = (state_q != IDLE) || (count_q != '0);
    assign head        = fifo_mem[rd_ptr];

    // Request FIFO: storage is data only, pointers and occupancy are control
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_write, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = ISSUE;
            ISSUE:   if (issue_done || issue_timeout) state_d = RESP;
            RESP:    if (rsp_take) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: decoded controls; mem_ready outside ISSUE is never looked at
    always_comb begin
        push       = req_valid && !full;
        pop        = (state_q == IDLE) && (count_q != '0);
        issue_done = (state_q == ISSUE) && mem_ready;
        rsp_take   = (state_q == RESP) && rsp_valid && rsp_ready;
    end

    // Registered controller and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_write        <= 1'b0;
            rsp_rdata        <= '0;
        end else begin
            if (pop) begin
                mem_address      <= head[ADDR_W+DATA_W-1:DATA_W];
                mem_write_data   <= head[DATA_W-1:0];
                mem_write_enable <= head[ENTRY_W-1];
                mem_read_enable  <= !head[ENTRY_W-1];
            end else if (issue_done || issue_timeout) begin
                mem_write_enable <= 1'b0;
                mem_read_enable  <= 1'b0;
            end

            // mem_write_enable still identifies the in-flight op while in ISSUE
            if (issue_done) begin
                rsp_valid <= 1'b1;
                rsp_write <= mem_write_enable;
                rsp_rdata <= mem_write_enable ? '0 : mem_read_data;
            end else if (issue_timeout) begin
                rsp_valid <= 1'b1;
                rsp_write <= mem_write_enable;
                rsp_rdata <= '0;
            end else if (rsp_take) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef DDRQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counter is zero on the first ISSUE cycle because ISSUE is only entered from IDLE
    assign issue_timeout = (state_q == ISSUE) && !mem_ready &&
                           (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            rsp_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (state_q != ISSUE) begin
                tmo_cnt <= '0;
            end else if (!issue_timeout) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (issue_done) begin
                rsp_err <= 1'b0;
            end else if (issue_timeout) begin
                rsp_err     <= 1'b1;
                timeout_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    // TIMEOUT_CYCLES has no effect when the abort path is not built
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign issue_timeout      = 1'b0;
    assign rsp_err            = 1'b0;
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_request_queue.sv
// Self-checking bench for ddr_request_queue: vector table, directed corner sequences,
// and randomized traffic against an in-order scoreboard with a behavioural controller.
module tb_ddr_request_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int TMO   = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_read_enable;
    logic          mem_write_enable;
    logic [DW-1:0] mem_read_data = '0;
    logic          mem_ready = 1'b0;
    logic [CW-1:0] queue_count;
    logic          busy;
    logic          timeout_err;

    always #5 clk = ~clk;

    ddr_request_queue #(
        .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready),
        .queue_count(queue_count), .busy(busy), .timeout_err(timeout_err)
    );

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    // Behavioural ddr_controller: ready pulses lat cycles after it first sees an enable
    bit [31:0]   ctrl_mem [256];
    bit          ctrl_has [256];
    int          lat = 0;
    bit          stuck = 1'b0;
    bit          allow_drop = 1'b0;
    bit          pending = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] op_addr = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    bit          both_high = 1'b0;
    bit          drop_early = 1'b0;
    bit          addr_moved = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ready <= 1'b0;
            pending   <= 1'b0;
            wait_cnt  <= 0;
        end else begin
            if (mem_read_enable && mem_write_enable) both_high <= 1'b1;
            if (mem_ready) begin
                mem_ready <= 1'b0;
                pending   <= 1'b0;
                wait_cnt  <= 0;
            end else if (mem_read_enable || mem_write_enable) begin
                if (pending && mem_address != op_addr) addr_moved <= 1'b1;
                pending <= 1'b1;
                op_addr <= mem_address;
                if (!stuck && wait_cnt >= lat) begin
                    mem_ready <= 1'b1;
                    last_addr <= mem_address;
                    if (mem_write_enable) begin
                        ctrl_mem[mem_address[7:0]] <= mem_write_data;
                        ctrl_has[mem_address[7:0]] <= 1'b1;
                        last_wdata <= mem_write_data;
                    end else begin
                        mem_read_data <= ctrl_has[mem_address[7:0]] ?
                                         ctrl_mem[mem_address[7:0]] : dflt(mem_address);
                    end
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end else begin
                if (pending && !allow_drop) drop_early <= 1'b1;
                pending  <= 1'b0;
                wait_cnt <= 0;
            end
        end
    end

    // Reference: in-order list of expected responses, memory image updated at accept time
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_cycles;
        logic        exp_write;
        logic [31:0] exp_rdata;
    } vec_t;

    exp_t        sb_q [$];
    logic [31:0] ref_mem [256];
    bit          sb_en = 1'b1;
    int          rsp_seen = 0;
    int          tests = 0;
    int          fails = 0;
    vec_t        vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: log handshakes seen before the edge, then advance to #1 after it
    task automatic step();
        exp_t        e;
        bit          hold;
        logic [31:0] hrd;
        logic        hw;
        hold = rsp_valid && !rsp_ready;
        hrd  = rsp_rdata;
        hw   = rsp_write;
        if (sb_en && req_valid && req_ready) begin
            e.write = req_write;
            e.addr  = req_addr;
            e.wdata = req_write ? req_wdata : 32'h0;
            if (req_write) begin
                ref_mem[req_addr[7:0]] = req_wdata;
                e.rdata = 32'h0;
            end else begin
                e.rdata = ref_mem[req_addr[7:0]];
            end
            sb_q.push_back(e);
        end
        if (rsp_valid && rsp_ready) begin
            rsp_seen++;
            if (sb_en) begin
                check("rsp_expected", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("rsp_write", rsp_write, e.write);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_op_addr", last_addr, e.addr);
                    check("rsp_err", rsp_err, 0);
                    if (e.write) check("rsp_mem_wdata", last_wdata, e.wdata);
                end
            end
        end
        @(posedge clk);
        #1;
        if (hold) begin
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_rdata", rsp_rdata, hrd);
            check("rsp_hold_write", rsp_write, hw);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  got;
        int  base;
        int  seen;

        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 0, 3, 1'b1, 32'h0};
        vecs[1] = '{1'b0, 32'h10, 32'h0,        0, 3, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 32'h20, 32'h12345678, 2, 5, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h20, 32'h0,        1, 4, 1'b0, 32'h12345678};
        vecs[4] = '{1'b0, 32'h30, 32'h0,        0, 3, 1'b0, 32'hC0DE0030};
        vecs[5] = '{1'b1, 32'h10, 32'h0,        3, 6, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 32'h10, 32'h0,        0, 3, 1'b0, 32'h0};

        for (int i = 0; i < 256; i++) ref_mem[i] = dflt(i);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_write", rsp_write, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_mem_rd_en", mem_read_enable, 0);
        check("rst_mem_wr_en", mem_write_enable, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        check("rst_count", queue_count, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single transactions on an idle queue: latency, enables, data, hold
        for (int i = 0; i < 7; i++) begin
            lat       = vecs[i].lat;
            rsp_ready = 1'b0;
            req_write = vecs[i].write;
            req_addr  = vecs[i].addr;
            req_wdata = vecs[i].wdata;
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            n   = 0;
            got = 1'b0;
            while (!got && n < 40) begin
                step();
                n++;
                if (n == 1) begin
                    check($sformatf("vec%0d_rd_en", i), mem_read_enable, !vecs[i].write);
                    check($sformatf("vec%0d_wr_en", i), mem_write_enable, vecs[i].write);
                end
                got = rsp_valid;
            end
            check($sformatf("vec%0d_latency", i), n, vecs[i].exp_cycles);
            check($sformatf("vec%0d_rsp_write", i), rsp_write, vecs[i].exp_write);
            check($sformatf("vec%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_rsp_err", i), rsp_err, 0);
            step();
            step();
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            check($sformatf("vec%0d_rsp_cleared", i), rsp_valid, 0);
            step();
        end

        // Fill: five writes with the requester stalled, sixth refused
        lat       = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 32'h50 + 4 * i;
            req_wdata = $urandom;
            step();
        end
        check("fill_count", queue_count, 4);
        check("fill_req_ready", req_ready, 0);
        check("fill_first_issued", mem_address, 32'h50);
        check("fill_busy", busy, 1);
        req_addr = 32'h64;
        repeat (3) step();
        req_valid = 1'b0;
        check("fill_count_hold", queue_count, 4);
        base      = rsp_seen;
        rsp_ready = 1'b1;
        for (int k = 0; k < 60 && (rsp_seen - base) < 5; k++) step();
        check("fill_acks", rsp_seen - base, 5);
        step();
        rsp_ready = 1'b0;
        check("fill_drained_count", queue_count, 0);
        check("fill_sb_empty", sb_q.size(), 0);

        // Reset during ISSUE with three entries queued
        stuck     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 32'h80 + 4 * i;
            req_wdata = $urandom;
            step();
        end
        req_valid = 1'b0;
        check("mid_count", queue_count, 3);
        check("mid_wr_en", mem_write_enable, 1);
`ifndef DDRQ_TIMEOUT_EN
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (rsp_valid) seen++;
        end
        check("stuck_no_rsp", seen, 0);
        check("stuck_wr_en_held", mem_write_enable, 1);
`endif
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_wr_en", mem_write_enable, 0);
        check("mid_rst_rd_en", mem_read_enable, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_count", queue_count, 0);
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        stuck = 1'b0;
        @(posedge clk);
        #1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (rsp_valid) seen++;
        end
        check("post_rst_no_rsp", seen, 0);
        check("post_rst_busy", busy, 0);

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_write = ($urandom_range(0, 1) == 1);
            req_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 6);
            lat       = $urandom_range(0, 2);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 300 && (sb_q.size() != 0 || busy); k++) step();
        check("rand_sb_empty", sb_q.size(), 0);
        check("rand_idle", busy, 0);
        check("rand_count", queue_count, 0);
        rsp_ready = 1'b0;
        step();

`ifdef DDRQ_TIMEOUT_EN
        // Timeout abort, then the next queued op completes normally
        sb_en      = 1'b0;
        stuck      = 1'b1;
        allow_drop = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h40;
        step();
        req_write  = 1'b1;
        req_addr   = 32'h44;
        req_wdata  = 32'hA5A5_0044;
        step();
        req_valid  = 1'b0;
        n   = 1;
        got = 1'b0;
        while (!got && n < 40) begin
            step();
            n++;
            got = rsp_valid;
        end
        check("tmo_latency", n, TMO + 1);
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_sticky", timeout_err, 1);
        check("tmo_rdata", rsp_rdata, 0);
        check("tmo_rsp_write", rsp_write, 0);
        check("tmo_enables_off", mem_read_enable | mem_write_enable, 0);
        stuck     = 1'b0;
        rsp_ready = 1'b1;
        step();
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            step();
            n++;
            got = rsp_valid;
        end
        check("tmo_next_done", got, 1);
        check("tmo_next_err", rsp_err, 0);
        check("tmo_next_write", rsp_write, 1);
        check("tmo_next_addr", last_addr, 32'h44);
        check("tmo_still_sticky", timeout_err, 1);
        step();
        rsp_ready = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("tmo_rst_clear", timeout_err, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
`endif

        check("never_both_enables", both_high, 0);
        check("enable_held_to_ready", drop_early, 0);
        check("addr_stable_in_issue", addr_moved, 0);
        check("final_timeout_err", timeout_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
